// File: rtl/rob_pkg.sv
// rtl/rob_pkg.sv - shared widths, FSM codes and entry field types for the reorder buffer
package rob_pkg;

  localparam int ARCHFILE_SIZE_DEF = 32;
  localparam int PHYSFILE_SIZE_DEF = 256;
  localparam int ROB_SIZE_DEF      = 16;

  localparam int ROB_TAG_W = $clog2(ROB_SIZE_DEF);
  localparam int ARCH_W    = $clog2(ARCHFILE_SIZE_DEF);
  localparam int PHYS_W    = $clog2(PHYSFILE_SIZE_DEF);

  localparam logic [0:0] RUN   = 1'b0;
  localparam logic [0:0] FLUSH = 1'b1;

  // Payload captured at rename and handed back at commit.
  typedef struct packed {
    logic              has_rd;
    logic [ARCH_W-1:0] arch_rd;
    logic [PHYS_W-1:0] phys_new;
    logic [PHYS_W-1:0] phys_old;
  } rob_payload_t;

endpackage

// File: rtl/rob_commit_if.sv
// rtl/rob_commit_if.sv - rename/ring/commit signal bundle between the ROB and its neighbours
interface rob_commit_if #(
  parameter int TAG_BITS  = rob_pkg::ROB_TAG_W,
  parameter int ARCH_BITS = rob_pkg::ARCH_W,
  parameter int PHYS_BITS = rob_pkg::PHYS_W
);

  logic                 alloc_valid;
  logic                 alloc_has_rd;
  logic [ARCH_BITS-1:0] alloc_arch_rd;
  logic [PHYS_BITS-1:0] alloc_phys_new;
  logic [PHYS_BITS-1:0] alloc_phys_old;
  logic                 alloc_ready;
  logic [TAG_BITS-1:0]  alloc_tag;

  logic                 ring_update;
  logic [TAG_BITS-1:0]  ring_tag;
  logic                 ring_exc;

  logic                 rob_update;
  logic [ARCH_BITS-1:0] arch_rob_update;
  logic [PHYS_BITS-1:0] arch_rob_nonspec_phys;
  logic [PHYS_BITS-1:0] phys_rob_free;
  logic                 rollback;
  logic                 empty;

  modport slave (
    input  alloc_valid, alloc_has_rd, alloc_arch_rd, alloc_phys_new, alloc_phys_old,
    output alloc_ready, alloc_tag,
    input  ring_update, ring_tag, ring_exc,
    output rob_update, arch_rob_update, arch_rob_nonspec_phys, phys_rob_free,
    output rollback, empty
  );

  modport master (
    output alloc_valid, alloc_has_rd, alloc_arch_rd, alloc_phys_new, alloc_phys_old,
    input  alloc_ready, alloc_tag,
    output ring_update, ring_tag, ring_exc,
    input  rob_update, arch_rob_update, arch_rob_nonspec_phys, phys_rob_free,
    input  rollback, empty
  );

endinterface

// File: rtl/rob_entry_array.sv
// rtl/rob_entry_array.sv - ROB entry storage: write at tail, ring-set-done, retire-clear, flash-clear
module rob_entry_array
  import rob_pkg::*;
#(
  parameter int ROB_SIZE  = ROB_SIZE_DEF,
  parameter int ARCH_BITS = ARCH_W,
  parameter int PHYS_BITS = PHYS_W,
  localparam int IDX_W    = $clog2(ROB_SIZE)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [IDX_W-1:0]     wr_idx,
  input  logic                 wr_has_rd,
  input  logic [ARCH_BITS-1:0] wr_arch_rd,
  input  logic [PHYS_BITS-1:0] wr_phys_new,
  input  logic [PHYS_BITS-1:0] wr_phys_old,
  input  logic                 set_en,
  input  logic [IDX_W-1:0]     set_idx,
  input  logic                 set_exc,
  input  logic                 ret_en,
  input  logic [IDX_W-1:0]     ret_idx,
  input  logic                 flash_clr,
  input  logic [IDX_W-1:0]     rd_idx,
  output logic                 rd_valid,
  output logic                 rd_done,
  output logic                 rd_exc,
  output logic                 rd_has_rd,
  output logic [ARCH_BITS-1:0] rd_arch_rd,
  output logic [PHYS_BITS-1:0] rd_phys_new,
  output logic [PHYS_BITS-1:0] rd_phys_old
);

  logic [ROB_SIZE-1:0]  valid;
  logic [ROB_SIZE-1:0]  done;
  logic [ROB_SIZE-1:0]  exc;
  logic                 has_rd_q [ROB_SIZE];
  logic [ARCH_BITS-1:0] arch_q   [ROB_SIZE];
  logic [PHYS_BITS-1:0] new_q    [ROB_SIZE];
  logic [PHYS_BITS-1:0] old_q    [ROB_SIZE];

  logic set_ok;

  // Completions for free slots, or for the slot being allocated right now, are stale.
  assign set_ok = set_en && valid[set_idx] && !(wr_en && (wr_idx == set_idx));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= '0;
      done  <= '0;
      exc   <= '0;
    end else if (flash_clr) begin
      valid <= '0;
      done  <= '0;
      exc   <= '0;
    end else begin
      if (set_ok) begin
        done[set_idx] <= 1'b1;
        exc[set_idx]  <= set_exc;
      end
      if (wr_en) begin
        valid[wr_idx] <= 1'b1;
        done[wr_idx]  <= 1'b0;
        exc[wr_idx]   <= 1'b0;
      end
      if (ret_en) begin
        valid[ret_idx] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      has_rd_q[wr_idx] <= wr_has_rd;
      arch_q[wr_idx]   <= wr_arch_rd;
      new_q[wr_idx]    <= wr_phys_new;
      old_q[wr_idx]    <= wr_phys_old;
    end
  end

  assign rd_valid    = valid[rd_idx];
  assign rd_done     = done[rd_idx];
  assign rd_exc      = exc[rd_idx];
  assign rd_has_rd   = has_rd_q[rd_idx];
  assign rd_arch_rd  = arch_q[rd_idx];
  assign rd_phys_new = new_q[rd_idx];
  assign rd_phys_old = old_q[rd_idx];

endmodule

// File: rtl/rob_commit.sv
// rtl/rob_commit.sv - in-order ROB commit/rollback control; ROB_STATS_EN adds commit/flush counters
module rob_commit
  import rob_pkg::*;
#(
  parameter int ARCHFILE_SIZE = ARCHFILE_SIZE_DEF,
  parameter int PHYSFILE_SIZE = PHYSFILE_SIZE_DEF,
  parameter int ROB_SIZE      = ROB_SIZE_DEF
) (
  input  logic        clk,
  input  logic        rst,
`ifdef ROB_STATS_EN
  output logic [31:0] commit_cnt,
  output logic [15:0] flush_cnt,
`endif
  rob_commit_if.slave bus
);

  localparam int TAG_W = $clog2(ROB_SIZE);
  localparam int CNT_W = TAG_W + 1;
  localparam int A_W   = $clog2(ARCHFILE_SIZE);
  localparam int P_W   = $clog2(PHYSFILE_SIZE);

  logic [0:0]       state;
  logic [TAG_W-1:0] head;
  logic [TAG_W-1:0] tail;
  logic [CNT_W-1:0] count;

  logic             full;
  logic             alloc_fire;
  logic             retire;
  logic             except;

  logic             head_valid;
  logic             head_done;
  logic             head_exc;
  logic             head_has_rd;
  logic [A_W-1:0]   head_arch_rd;
  logic [P_W-1:0]   head_phys_new;
  logic [P_W-1:0]   head_phys_old;

  logic             rob_update_q;
  logic             rollback_q;
  logic [A_W-1:0]   arch_q;
  logic [P_W-1:0]   nonspec_q;
  logic [P_W-1:0]   free_q;

  assign full            = (count == CNT_W'(ROB_SIZE));
  assign bus.alloc_ready = (state == RUN) && !full && !rollback_q;
  assign bus.alloc_tag   = tail;
  assign bus.empty       = (count == '0);

  assign alloc_fire = bus.alloc_valid && bus.alloc_ready;
  assign retire     = (state == RUN) && head_valid && head_done && !head_exc;
  assign except     = (state == RUN) && head_valid && head_done && head_exc;

  rob_entry_array #(
    .ROB_SIZE  (ROB_SIZE),
    .ARCH_BITS (A_W),
    .PHYS_BITS (P_W)
  ) u_entries (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (alloc_fire),
    .wr_idx      (tail),
    .wr_has_rd   (bus.alloc_has_rd),
    .wr_arch_rd  (bus.alloc_arch_rd),
    .wr_phys_new (bus.alloc_phys_new),
    .wr_phys_old (bus.alloc_phys_old),
    .set_en      (bus.ring_update && (state == RUN)),
    .set_idx     (bus.ring_tag),
    .set_exc     (bus.ring_exc),
    .ret_en      (retire),
    .ret_idx     (head),
    .flash_clr   (state == FLUSH),
    .rd_idx      (head),
    .rd_valid    (head_valid),
    .rd_done     (head_done),
    .rd_exc      (head_exc),
    .rd_has_rd   (head_has_rd),
    .rd_arch_rd  (head_arch_rd),
    .rd_phys_new (head_phys_new),
    .rd_phys_old (head_phys_old)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (state == FLUSH) begin
      state <= RUN;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (except) state <= FLUSH;
      if (alloc_fire) tail <= tail + 1'b1;
      if (retire) head <= head + 1'b1;
      count <= count + CNT_W'(alloc_fire) - CNT_W'(retire);
    end
  end

  // Commit data registers only move on a real architectural update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rob_update_q <= 1'b0;
      rollback_q   <= 1'b0;
      arch_q       <= '0;
      nonspec_q    <= '0;
      free_q       <= '0;
    end else begin
      rob_update_q <= retire && head_has_rd;
      rollback_q   <= except;
      if (retire && head_has_rd) begin
        arch_q    <= head_arch_rd;
        nonspec_q <= head_phys_new;
        free_q    <= head_phys_old;
      end
    end
  end

  assign bus.rob_update            = rob_update_q;
  assign bus.rollback              = rollback_q;
  assign bus.arch_rob_update       = arch_q;
  assign bus.arch_rob_nonspec_phys = nonspec_q;
  assign bus.phys_rob_free         = free_q;

`ifdef ROB_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      commit_cnt <= '0;
      flush_cnt  <= '0;
    end else begin
      if (retire && (commit_cnt != '1)) commit_cnt <= commit_cnt + 1'b1;
      if (except && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_rob_commit.sv
// tb/tb_rob_commit.sv - directed self-checking bench for rob_commit
module tb_rob_commit;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  rob_commit_if bus ();

  rob_commit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.alloc_valid    = 1'b0;
    bus.alloc_has_rd   = 1'b0;
    bus.alloc_arch_rd  = '0;
    bus.alloc_phys_new = '0;
    bus.alloc_phys_old = '0;
    bus.ring_update    = 1'b0;
    bus.ring_tag       = '0;
    bus.ring_exc       = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic do_alloc(input logic has_rd, input logic [4:0] arch, input logic [7:0] pnew,
                          input logic [7:0] pold);
    bus.alloc_valid    = 1'b1;
    bus.alloc_has_rd   = has_rd;
    bus.alloc_arch_rd  = arch;
    bus.alloc_phys_new = pnew;
    bus.alloc_phys_old = pold;
    step();
    bus.alloc_valid = 1'b0;
  endtask

  task automatic do_ring(input logic [3:0] tag, input logic exc);
    bus.ring_update = 1'b1;
    bus.ring_tag    = tag;
    bus.ring_exc    = exc;
    step();
    bus.ring_update = 1'b0;
    bus.ring_exc    = 1'b0;
  endtask

  initial begin
    // reset state
    idle_inputs();
    @(negedge clk);
    check("rst_rob_update", 32'(bus.rob_update), 0);
    check("rst_rollback", 32'(bus.rollback), 0);
    check("rst_empty", 32'(bus.empty), 1);
    check("rst_alloc_tag", 32'(bus.alloc_tag), 0);
    check("rst_arch", 32'(bus.arch_rob_update), 0);
    check("rst_free", 32'(bus.phys_rob_free), 0);
    rst = 1'b1;

    // single commit, two cycles after the ring update
    do_alloc(1'b1, 5'h0d, 8'h21, 8'h0d);
    check("t1_tag_after_alloc", 32'(bus.alloc_tag), 1);
    check("t1_not_empty", 32'(bus.empty), 0);
    do_ring(4'd0, 1'b0);
    check("t1_no_early_commit", 32'(bus.rob_update), 0);
    step();
    check("t1_rob_update", 32'(bus.rob_update), 1);
    check("t1_arch", 32'(bus.arch_rob_update), 32'h0d);
    check("t1_nonspec", 32'(bus.arch_rob_nonspec_phys), 32'h21);
    check("t1_free", 32'(bus.phys_rob_free), 32'h0d);
    step();
    check("t1_pulse_one_cycle", 32'(bus.rob_update), 0);
    check("t1_arch_hold", 32'(bus.arch_rob_update), 32'h0d);
    check("t1_empty", 32'(bus.empty), 1);

    // out-of-order completion, in-order commit
    apply_reset();
    for (int i = 0; i < 3; i++) do_alloc(1'b1, 5'(i + 1), 8'(8'h41 + i), 8'(8'h11 + i));
    do_ring(4'd2, 1'b0);
    check("t2_wait_after_2", 32'(bus.rob_update), 0);
    do_ring(4'd1, 1'b0);
    check("t2_wait_after_1", 32'(bus.rob_update), 0);
    do_ring(4'd0, 1'b0);
    check("t2_wait_after_0", 32'(bus.rob_update), 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t2_commit_pulse", 32'(bus.rob_update), 1);
      check("t2_commit_arch", 32'(bus.arch_rob_update), 32'(i + 1));
      check("t2_commit_new", 32'(bus.arch_rob_nonspec_phys), 32'(8'h41 + i));
      check("t2_commit_old", 32'(bus.phys_rob_free), 32'(8'h11 + i));
    end
    step();
    check("t2_done_pulse", 32'(bus.rob_update), 0);
    check("t2_empty", 32'(bus.empty), 1);

    // full, dropped alloc, wrap
    apply_reset();
    for (int i = 0; i < 16; i++) do_alloc(1'b1, 5'(i), 8'(8'h80 + i), 8'(i));
    check("t3_full_not_ready", 32'(bus.alloc_ready), 0);
    check("t3_full_tag_wrap", 32'(bus.alloc_tag), 0);
    do_alloc(1'b1, 5'h1e, 8'hee, 8'h1e);
    check("t3_drop_tag", 32'(bus.alloc_tag), 0);
    do_ring(4'd0, 1'b0);
    check("t3_ready_still_0", 32'(bus.alloc_ready), 0);
    step();
    check("t3_commit", 32'(bus.rob_update), 1);
    check("t3_commit_arch", 32'(bus.arch_rob_update), 0);
    check("t3_commit_new", 32'(bus.arch_rob_nonspec_phys), 32'h80);
    check("t3_ready_after", 32'(bus.alloc_ready), 1);
    check("t3_tag_wrap", 32'(bus.alloc_tag), 0);
    do_alloc(1'b1, 5'h1f, 8'hff, 8'h1f);
    check("t3_tag_after_wrap", 32'(bus.alloc_tag), 1);
    check("t3_full_again", 32'(bus.alloc_ready), 0);

    // exception at head -> rollback and flush
    apply_reset();
    for (int i = 0; i < 4; i++) do_alloc(1'b1, 5'(i + 4), 8'(8'h50 + i), 8'(i + 4));
    do_ring(4'd0, 1'b1);
    check("t4_no_rb_yet", 32'(bus.rollback), 0);
    bus.ring_update = 1'b1;
    bus.ring_tag    = 4'd2;
    step();
    check("t4_rollback", 32'(bus.rollback), 1);
    check("t4_no_commit", 32'(bus.rob_update), 0);
    check("t4_not_ready_in_flush", 32'(bus.alloc_ready), 0);
    step();
    bus.ring_update = 1'b0;
    check("t4_rollback_one_cycle", 32'(bus.rollback), 0);
    check("t4_empty", 32'(bus.empty), 1);
    check("t4_ready", 32'(bus.alloc_ready), 1);
    check("t4_tag_zero", 32'(bus.alloc_tag), 0);
    do_ring(4'd2, 1'b0);
    step();
    step();
    check("t4_late_ring_ignored", 32'(bus.rob_update), 0);
    check("t4_arch_untouched", 32'(bus.arch_rob_update), 0);
    check("t4_still_empty", 32'(bus.empty), 1);

    // silent retire then normal commit
    apply_reset();
    do_alloc(1'b0, 5'h05, 8'h55, 8'h15);
    do_alloc(1'b1, 5'h06, 8'h66, 8'h16);
    do_ring(4'd1, 1'b0);
    do_ring(4'd0, 1'b0);
    check("t5_wait", 32'(bus.rob_update), 0);
    step();
    check("t5_silent", 32'(bus.rob_update), 0);
    check("t5_silent_arch", 32'(bus.arch_rob_update), 0);
    step();
    check("t5_next_commit", 32'(bus.rob_update), 1);
    check("t5_next_arch", 32'(bus.arch_rob_update), 32'h06);
    check("t5_next_new", 32'(bus.arch_rob_nonspec_phys), 32'h66);
    check("t5_next_free", 32'(bus.phys_rob_free), 32'h16);

    // asynchronous reset mid-operation
    apply_reset();
    for (int i = 0; i < 5; i++) do_alloc(1'b1, 5'(i + 9), 8'(8'h90 + i), 8'(i + 9));
    do_ring(4'd0, 1'b0);
    do_ring(4'd1, 1'b0);
    rst = 1'b0;
    #1;
    check("t6_rob_update", 32'(bus.rob_update), 0);
    check("t6_empty", 32'(bus.empty), 1);
    check("t6_arch", 32'(bus.arch_rob_update), 0);
    check("t6_nonspec", 32'(bus.arch_rob_nonspec_phys), 0);
    check("t6_tag", 32'(bus.alloc_tag), 0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t6_no_commit", 32'(bus.rob_update), 0);
    end
    check("t6_empty_after", 32'(bus.empty), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rob_commit.md
Name: rob_commit

Overview:
- In-order reorder buffer that drives the commit side of regfile_TOP: rob_update, arch_rob_update, arch_rob_nonspec_phys, phys_rob_free, rollback.
- Rename allocates one entry per cycle; the ring result bus marks entries done or excepting; the head retires at most one entry per cycle.
- An excepting head triggers a one-cycle rollback and a full flush.

Parameters:
- ARCHFILE_SIZE, 32, architectural registers.
- PHYSFILE_SIZE, 256, physical registers.
- ROB_SIZE, 16, entries; power of two, ≥2.

Ports:
- clk  in  1  clock; all state on posedge.
- rst  in  1  asynchronous, active-low reset.
- alloc_valid  in  1  rename allocates an entry this cycle.
- alloc_has_rd  in  1  instruction writes a destination (0 for no rd or rd==x0).
- alloc_arch_rd  in  log2(ARCHFILE_SIZE)  destination arch register.
- alloc_phys_new  in  log2(PHYSFILE_SIZE)  newly mapped phys register.
- alloc_phys_old  in  log2(PHYSFILE_SIZE)  previous mapping, freed at commit.
- alloc_ready  out  1  entry available; combinational.
- alloc_tag  out  log2(ROB_SIZE)  tail index given to the allocating uop; combinational.
- ring_update  in  1  completion broadcast.
- ring_tag  in  log2(ROB_SIZE)  completing entry.
- ring_exc  in  1  completion carries an exception.
- rob_update  out  1  registered one-cycle commit pulse.
- arch_rob_update  out  log2(ARCHFILE_SIZE)  committed arch register.
- arch_rob_nonspec_phys  out  log2(PHYSFILE_SIZE)  new non-speculative mapping.
- phys_rob_free  out  log2(PHYSFILE_SIZE)  phys register returned to the free list.
- rollback  out  1  registered one-cycle flush pulse.
- empty  out  1  count==0.

Behaviour:
- Reset (rst=0, asynchronous):
  - head=tail=count=0; all entry valid/done/exc bits cleared; state=RUN.
  - rob_update=0, rollback=0, arch_rob_update=0, arch_rob_nonspec_phys=0, phys_rob_free=0, empty=1.
  - Reset mid-operation discards all entries with no commit pulse.
- Entry fields: valid, done, exc, has_rd, arch_rd, phys_new, phys_old.
- Pointers: head and tail wrap modulo ROB_SIZE. count is log2(ROB_SIZE)+1 bits so full (count==ROB_SIZE) and empty (count==0) are distinct.
- alloc_ready = (state==RUN) && !full && !rollback.
- Allocation: alloc_valid && alloc_ready writes the entry at tail with valid=1, done=0, exc=0, then tail++. alloc_valid while not ready is dropped; rename must hold.
- Ring:
  - ring_update sets done (and exc = ring_exc) for entry ring_tag, only if that entry is valid; otherwise ignored.
  - A ring write to an entry in the same cycle as its allocation is impossible by protocol; the ROB ignores it.
- Commit (state RUN): evaluated on head, combinationally, every cycle.
  - head valid & done & !exc: retire. Clear valid, head++.
    - If has_rd: next cycle rob_update=1, arch_rob_update=arch_rd, arch_rob_nonspec_phys=phys_new, phys_rob_free=phys_old.
    - If !has_rd: retire silently, rob_update=0.
  - head valid & done & exc: go to FLUSH. Next cycle rollback=1; the entry does not update the arch map.
- Latency: ring_update on the head sampled at edge k sets done; the commit decision is made in the cycle after edge k; rob_update is high in the cycle after edge k+1.
- Throughput: one commit per cycle.
- Data outputs hold their last value when rob_update=0.
- FSM:
  - RUN -> FLUSH on an excepting head.
  - FLUSH (exactly one cycle, rollback=1): clear all valid bits, head=tail=count=0, ignore ring and alloc.
  - FLUSH -> RUN unconditionally.
- Simultaneous alloc and commit in one cycle: count unchanged. When full, a same-cycle commit does not enable allocation; alloc_ready rises the next cycle.

Optional Feature:
- Macro ROB_STATS_EN.
- Defined: adds outputs commit_cnt (32 bits, increments on every retire including silent ones) and flush_cnt (16 bits, increments per rollback). Both saturate, reset to 0.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package rob_pkg holds:
  - localparams ROB_SIZE_DEF, ROB_TAG_W, ARCH_W, PHYS_W.
  - FSM encodings RUN=1'b0, FLUSH=1'b1.
  - Entry field widths, shared with rename and the ring driver.
- One sub-module, rob_entry_array: the ROB_SIZE-deep entry storage with write-at-tail, ring-set-done and flash-clear ports. Pointers, FSM and output registers stay in rob_commit.

Test Plan:
- Reset then allocate (has_rd=1, arch 0x0d, new 0x21, old 0x0d); ring tag 0 -> two cycles later rob_update=1, arch_rob_update=0x0d, arch_rob_nonspec_phys=0x21, phys_rob_free=0x0d for exactly one cycle.
- Allocate tags 0,1,2; ring completes 2, then 1, then 0 -> commits emitted in order 0,1,2 on consecutive cycles, none before tag 0 completes.
- Fill 16 entries -> alloc_ready=0, 17th alloc dropped; complete head -> alloc_ready=1 the cycle after the commit; tail wraps to tag 0.
- Allocate 4; ring tag 0 with ring_exc=1 -> rollback=1 for one cycle, rob_update stays 0, empty=1 next cycle, late ring on tag 2 ignored.
- alloc_has_rd=0 entry completes -> retires with rob_update=0; the following has_rd entry commits the next cycle.
- rst pulled low with 5 entries pending -> all outputs 0 immediately, empty=1, no commit after rst releases.
